y86_prefetch_fetch: RTL
=======================

# y86_prefetch_fetch

Parametrised Y86-64 fetch stage with a byte prefetch queue. It streams bytes from a synchronous instruction memory and keeps a circular byte queue full. It decodes the instruction at the queue head, with variable length of 1, 2, 9 or 10 bytes, and presents it to decode over a valid/ready handshake. It sits between instruction memory and the decode stage of the pipelined core, and accepts PC redirects from execute/writeback.

## Interface
- RESET_PC, 64'h0, fetch PC loaded on reset
- IMEM_BYTES, 256, instruction memory size in bytes; byte addresses at or above this value are out of range
- FETCH_BYTES, 4, bytes returned per memory read; must be 1, 2, 4 or 8
- QUEUE_BYTES, 16, byte queue capacity; must be a power of 2 and ≥ 10 + FETCH_BYTES
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  read request this cycle
- imem_addr  out  64  byte address of the read; not required to be aligned
- imem_rdata  in  8*FETCH_BYTES  bytes addr..addr+FETCH_BYTES-1, little-endian, byte 0 in [7:0]; valid the cycle after imem_req
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  64  new fetch PC
- out_valid  out  1  decoded instruction available
- out_ready  in  1  decode accepts the instruction
- pc, valP, valC  out  64  instruction address, pc + length, constant field
- icode, ifun, rA, rB  out  4  decoded fields
- halt, invalid_instr, memory_error  out  1  status of the presented instruction

## Operation
- State: fetch PC fpc, queue of QUEUE_BYTES entries, head PC hpc, byte count cnt, in-flight flag infl, run/halted flag.
- Each queue entry holds 8 data bits plus 1 error bit.
- Request rule: in RUN, with no redirect this cycle, when cnt + (infl ? FETCH_BYTES : 0) + FETCH_BYTES ≤ QUEUE_BYTES:
  - Drive imem_req=1 and imem_addr=fpc.
  - Then fpc += FETCH_BYTES, modulo 2^64, with no special wrap handling, and infl is set.
  - Pops in the same cycle are ignored when evaluating this rule.
- Response: the cycle after a request, all FETCH_BYTES bytes are pushed at the queue tail.
  - A byte whose address is ≥ IMEM_BYTES is pushed as 8'h00 with error=1.
  - A request whose first address is ≥ IMEM_BYTES is still issued; its bytes are all marked error.
- Length by head icode:
  - 0, 1, 9 give 1 byte.
  - 2, 6, A, B give 2 bytes.
  - 7, 8 give 9 bytes.
  - 3, 4, 5 give 10 bytes.
  - icode ≥ C gives 1 byte and invalid_instr=1.
- Field extraction:
  - Byte 0 gives icode and ifun.
  - For icodes 2, 3, 4, 5, 6, A, B, byte 1 gives rA = [7:4] and rB = [3:0].
  - valC comes from bytes 1..8 for icodes 7 and 8, and from bytes 2..9 for icodes 3, 4, 5, little-endian.
  - Fields not used by the icode are driven 0.
- out_valid=1 in RUN when cnt ≥ length.
  - memory_error = OR of the error bits over the instruction's bytes.
  - halt = (icode==0).
- Handshake: out_valid & out_ready pops length bytes and sets hpc += length.
  - Outputs are combinational from the queue head and must stay stable while out_valid=1 and out_ready=0.
  - When out_valid=0, all output fields are 0.
- Halting: an accepted instruction with halt, invalid_instr or memory_error moves the block to HALTED.
  - In HALTED: no requests, out_valid=0, and any in-flight response is discarded.
  - Only a redirect or reset leaves HALTED.
- Redirect, which has priority over all other updates:
  - Empty the queue (cnt=0) and discard any response arriving next cycle.
  - Set fpc=hpc=redirect_pc and enter RUN.
  - A handshake in the same cycle still counts as accepted, and the flush follows it.
  - A redirect in the same cycle as an accepted halt leaves the block in RUN.

## Timing
- Reset values:
  - fpc=hpc=RESET_PC, cnt=0, infl=0, RUN.
  - imem_req=0, out_valid=0, every output field 0.
- Reset asserted mid-operation clears everything immediately. Responses to pre-reset requests are dropped.
- Latency: request in cycle N, bytes in queue at the edge ending N+1, out_valid earliest in N+2.
  - With FETCH_BYTES=4, the first request occurs the cycle after reset deasserts.
- A redirect in cycle N gives imem_req=1 with addr=redirect_pc in N+1 and out_valid earliest in N+3.
- Throughput: one instruction per cycle when queued bytes suffice. Sustained bandwidth is FETCH_BYTES per cycle.
- Full queue: imem_req stays 0 while the request rule fails, and no byte is ever lost or overwritten.

## Test plan
- Reset, FETCH_BYTES=4, memory 30 F2 0A 00 00 00 00 00 00 00 60 23 00:
  - Expect irmovq: icode 3, rB 2, valC 10, valP 10.
  - Then addq: icode 6, ifun 0, rA 2, rB 3, valP 12.
  - Then halt=1, valP 13. After that, out_valid=0 and imem_req=0 forever.
- Hold out_ready=0 for 20 cycles:
  - Outputs are unchanged.
  - cnt peaks at 16 and imem_req=0 once the request rule fails.
  - Release out_ready: the instruction sequence continues with no gap or duplicate.
- Put jmp 0x40 (70 40 00.. ) at 0, assert redirect_valid with redirect_pc=0x40 in the accept cycle, while a request is in flight:
  - The next presented pc is 0x40; no stale bytes appear.
- IMEM_BYTES=256, irmovq at 250:
  - memory_error=1, valP 260; block enters HALTED.
  - A redirect to 0 restarts fetch.
- Byte C0 at pc 5: invalid_instr=1, valP 6, then HALTED.
- Assert reset during a pending response: the response is dropped, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/y86_prefetch_fetch.sv
// Y86-64 fetch stage: streams FETCH_BYTES-wide reads into a circular byte queue
// and presents the variable-length instruction at the queue head to decode.
module y86_prefetch_fetch #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned IMEM_BYTES  = 256,
  parameter int unsigned FETCH_BYTES = 4,
  parameter int unsigned QUEUE_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [63:0]              imem_addr,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              pc,
  output logic [63:0]              valP,
  output logic [63:0]              valC,
  output logic [3:0]               icode,
  output logic [3:0]               ifun,
  output logic [3:0]               rA,
  output logic [3:0]               rB,
  output logic                     halt,
  output logic                     invalid_instr,
  output logic                     memory_error
);

  localparam int unsigned PW = $clog2(QUEUE_BYTES);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t               state, state_nx;
  logic [63:0]          fpc, hpc, raddr;
  logic [PW-1:0]        hd, tail;
  logic [CW-1:0]        cnt;
  logic                 infl, push, accept, stop;
  logic [7:0]           q_data [QUEUE_BYTES];
  logic                 q_err  [QUEUE_BYTES];
  logic [7:0]           hb [10];
  logic                 he [10];
  logic [FETCH_BYTES-1:0] rsp_err;
  logic [3:0]           len, h_ic;
  logic                 h_regs, h_c1, h_c2, h_inv, h_merr, h_valid;

  assign tail = hd + cnt[PW-1:0];
  // Only a response to a request issued while running is kept; a redirect or
  // halt clears infl / leaves RUN, so stale data never reaches the queue.
  assign push = infl && (state == RUN);

  always_comb begin
    for (int unsigned i = 0; i < FETCH_BYTES; i++)
      rsp_err[i] = (raddr + 64'(i)) >= 64'(IMEM_BYTES);
  end

  always_comb begin
    for (int unsigned i = 0; i < 10; i++) begin
      hb[i] = q_data[hd + PW'(i)];
      he[i] = q_err[hd + PW'(i)];
    end
    h_ic   = hb[0][7:4];
    len    = 4'd1;
    h_regs = 1'b0;
    h_c1   = 1'b0;
    h_c2   = 1'b0;
    h_inv  = 1'b0;
    case (h_ic)
      4'h0, 4'h1, 4'h9:       len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2;  h_regs = 1'b1; end
      4'h7, 4'h8:             begin len = 4'd9;  h_c1 = 1'b1; end
      4'h3, 4'h4, 4'h5:       begin len = 4'd10; h_regs = 1'b1; h_c2 = 1'b1; end
      default:                h_inv = 1'b1;
    endcase
    h_merr = 1'b0;
    for (int unsigned i = 0; i < 10; i++)
      if (4'(i) < len) h_merr = h_merr | he[i];
    h_valid = (state == RUN) && (cnt >= CW'(len));
  end

  always_comb begin
    imem_req  = !reset && (state == RUN) && !redirect_valid &&
                (32'(cnt) + (infl ? FETCH_BYTES : 0) + FETCH_BYTES <= QUEUE_BYTES);
    imem_addr = fpc;
    out_valid     = h_valid;
    pc            = '0;
    valP          = '0;
    valC          = '0;
    icode         = '0;
    ifun          = '0;
    rA            = '0;
    rB            = '0;
    halt          = 1'b0;
    invalid_instr = 1'b0;
    memory_error  = 1'b0;
    if (h_valid) begin
      pc            = hpc;
      valP          = hpc + 64'(len);
      icode         = h_ic;
      ifun          = hb[0][3:0];
      halt          = (h_ic == 4'h0);
      invalid_instr = h_inv;
      memory_error  = h_merr;
      if (h_regs) begin
        rA = hb[1][7:4];
        rB = hb[1][3:0];
      end
      if (h_c1) valC = {hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2], hb[1]};
      if (h_c2) valC = {hb[9], hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2]};
    end
    accept = h_valid && out_ready;
    stop   = accept && (halt || invalid_instr || memory_error);
    state_nx = state;
    if (redirect_valid)
      state_nx = RUN;
    else if (stop)
      state_nx = HALTED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc   <= RESET_PC;
      hpc   <= RESET_PC;
      raddr <= '0;
      hd    <= '0;
      cnt   <= '0;
      infl  <= 1'b0;
    end else if (redirect_valid) begin
      fpc  <= redirect_pc;
      hpc  <= redirect_pc;
      cnt  <= '0;
      infl <= 1'b0;
    end else begin
      infl <= imem_req;
      if (imem_req) begin
        fpc   <= fpc + 64'(FETCH_BYTES);
        raddr <= fpc;
      end
      if (accept) begin
        hpc <= hpc + 64'(len);
        hd  <= hd + PW'(len);
      end
      cnt <= cnt + (push ? CW'(FETCH_BYTES) : CW'(0)) - (accept ? CW'(len) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (push && !redirect_valid) begin
      for (int unsigned i = 0; i < FETCH_BYTES; i++) begin
        q_data[tail + PW'(i)] <= rsp_err[i] ? 8'h00 : imem_rdata[8*i +: 8];
        q_err[tail + PW'(i)]  <= rsp_err[i];
      end
    end
  end

endmodule
